step_sequencer: RTL and testbench

//  Parametrised multicycle step sequencer, the next-generation timing core of the Control unit.

---
 rtl/step_sequencer_pkg.sv | 17 +
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/step_sequencer.sv | 106 ++++++++++
 tb/tb_step_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/step_sequencer_pkg.sv
// Shared types for the step sequencer: FSM state encoding and a state helper.
package step_sequencer_pkg;

  // 2-bit state encoding, also exposed on the debug state output.
  typedef enum logic [1:0] {
    SEQ_RUN   = 2'd0,
    SEQ_WAIT  = 2'd1,
    SEQ_HALT  = 2'd2,
    SEQ_FAULT = 2'd3
  } seq_state_t;

  // True in the states where the sequencer may advance and cycles are counted.
  function automatic logic seq_active(input seq_state_t s);
    return (s == SEQ_RUN) || (s == SEQ_WAIT);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait tracking for one step: remembers an early ack and counts wait cycles.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iActive,
  input  logic iInWait,
  input  logic iAdv,
  input  logic iMemReq,
  input  logic iMemAck,
  output logic oMemOk,
  output logic oTimeout
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_VAL = WC_W'(MEM_TIMEOUT);

  logic [WC_W-1:0] wait_cnt;
  logic            ack_seen;
  logic            pending;

  // A request is still outstanding when neither a live nor a remembered ack exists.
  assign pending  = iMemReq & ~iMemAck & ~ack_seen;
  assign oMemOk   = ~pending;
  // wait_cnt is 1 during the first WAIT cycle, so the timeout fires in WAIT cycle MEM_TIMEOUT.
  assign oTimeout = iInWait & pending & (wait_cnt == TIMEOUT_VAL);

  // Count cycles with an outstanding request; latch an ack that arrives while the datapath stalls.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wait_cnt <= '0;
      ack_seen <= 1'b0;
    end else if (iAdv) begin
      wait_cnt <= '0;
      ack_seen <= 1'b0;
    end else if (iActive) begin
      if (iMemReq & iMemAck) ack_seen <= 1'b1;
      if (pending && (wait_cnt != TIMEOUT_VAL)) wait_cnt <= wait_cnt + WC_W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Multicycle step sequencer: one-hot step vector, memory-stretch, halt/resume, fault, perf counters.
// Handshake: a memory step completes when iMemReq is low, or iMemAck is high in that cycle,
// or an ack was already seen for this step; the step then advances on the first cycle with iRdy.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int STEP_MAX    = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iRdy,
  input  logic                iLastStep,
  input  logic                iHalt,
  input  logic                iResume,
  input  logic                iMemReq,
  input  logic                iMemAck,
  output logic [STEP_MAX-1:0] oStep,
  output logic                oIREn,
  output logic                oRetire,
  output logic                oStall,
  output logic                oHalted,
  output logic                oFault,
  output logic [CNT_W-1:0]    oInstrCnt,
  output logic [CNT_W-1:0]    oCycleCnt,
  output seq_state_t          oState
);

  localparam logic [STEP_MAX-1:0] STEP_FETCH = {{(STEP_MAX-1){1'b0}}, 1'b1};

  seq_state_t          state;
  logic [STEP_MAX-1:0] step_q;
  logic [CNT_W-1:0]    instr_cnt;
  logic [CNT_W-1:0]    cycle_cnt;

  logic active, in_wait, mem_ok, timeout, adv;
  logic at_fetch, halt_req, end_instr;

  assign active    = seq_active(state);
  assign in_wait   = (state == SEQ_WAIT);
  // Reset blocks advance so the combinational strobes read 0 while iRst is high.
  assign adv       = ~iRst & iRdy & mem_ok & active;
  assign at_fetch  = step_q[0];
  assign halt_req  = iHalt & ~at_fetch;
  assign end_instr = (iLastStep & ~at_fetch) | step_q[STEP_MAX-1] | halt_req;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .iClk    (iClk),
    .iRst    (iRst),
    .iActive (active),
    .iInWait (in_wait),
    .iAdv    (adv),
    .iMemReq (iMemReq),
    .iMemAck (iMemAck),
    .oMemOk  (mem_ok),
    .oTimeout(timeout)
  );

  // Control FSM with step shift and performance counters; FAULT freezes everything until reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= SEQ_RUN;
      step_q    <= STEP_FETCH;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (active) cycle_cnt <= cycle_cnt + CNT_W'(1);
      case (state)
        SEQ_RUN, SEQ_WAIT: begin
          if (adv) begin
            if (end_instr) begin
              step_q    <= STEP_FETCH;
              instr_cnt <= instr_cnt + CNT_W'(1);
            end else begin
              step_q <= step_q << 1;
            end
            state <= halt_req ? SEQ_HALT : SEQ_RUN;
          end else if (timeout) begin
            state <= SEQ_FAULT;
          end else if (iMemReq & ~mem_ok) begin
            state <= SEQ_WAIT;
          end
        end
        SEQ_HALT: begin
          if (iResume) state <= SEQ_RUN;
        end
        default: state <= SEQ_FAULT;
      endcase
    end
  end

  assign oStep     = step_q;
  assign oIREn     = adv & at_fetch;
  assign oRetire   = adv & end_instr;
  assign oStall    = ~iRst & active & ~adv;
  // Status flags are decoded straight from the state register.
  assign oHalted   = (state == SEQ_HALT);
  assign oFault    = (state == SEQ_FAULT);
  assign oInstrCnt = instr_cnt;
  assign oCycleCnt = cycle_cnt;
  assign oState    = state;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: main instance (timeout 255) and a short-timeout instance share inputs.
module tb_step_sequencer;
  import step_sequencer_pkg::*;

  localparam int STEP_MAX = 5;
  localparam int CNT_W    = 4;

  logic iClk = 1'b0;
  logic iRst, iRdy, iLastStep, iHalt, iResume, iMemReq, iMemAck;

  logic [STEP_MAX-1:0] oStep, t_step;
  logic oIREn, oRetire, oStall, oHalted, oFault;
  logic t_iren, t_retire, t_stall, t_halted, t_fault;
  logic [CNT_W-1:0] oInstrCnt, oCycleCnt, t_instr, t_cycle;
  seq_state_t oState, t_state;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cyc;
  int n_idle;
  logic [9:0] exp_q[$];

  step_sequencer #(.STEP_MAX(STEP_MAX), .CNT_W(CNT_W), .MEM_TIMEOUT(255)) dut (
    .iClk(iClk), .iRst(iRst), .iRdy(iRdy), .iLastStep(iLastStep), .iHalt(iHalt),
    .iResume(iResume), .iMemReq(iMemReq), .iMemAck(iMemAck),
    .oStep(oStep), .oIREn(oIREn), .oRetire(oRetire), .oStall(oStall),
    .oHalted(oHalted), .oFault(oFault), .oInstrCnt(oInstrCnt), .oCycleCnt(oCycleCnt),
    .oState(oState)
  );

  step_sequencer #(.STEP_MAX(STEP_MAX), .CNT_W(CNT_W), .MEM_TIMEOUT(3)) dut_t (
    .iClk(iClk), .iRst(iRst), .iRdy(iRdy), .iLastStep(iLastStep), .iHalt(iHalt),
    .iResume(iResume), .iMemReq(iMemReq), .iMemAck(iMemAck),
    .oStep(t_step), .oIREn(t_iren), .oRetire(t_retire), .oStall(t_stall),
    .oHalted(t_halted), .oFault(t_fault), .oInstrCnt(t_instr), .oCycleCnt(t_cycle),
    .oState(t_state)
  );

  // Clock
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected {step,iren,retire,stall,halted,fault},
  // compare at the falling edge, return 1 time unit after the next rising edge.
  task automatic cyc(input string tag,
                     input logic rdy, input logic last, input logic halt,
                     input logic resume, input logic mreq, input logic mack,
                     input logic [4:0] e_step, input logic e_iren, input logic e_ret,
                     input logic e_stall, input logic e_halt, input logic e_fault);
    logic [9:0] obs;
    logic [9:0] exp;
    iRdy = rdy; iLastStep = last; iHalt = halt; iResume = resume;
    iMemReq = mreq; iMemAck = mack;
    exp_q.push_back({e_step, e_iren, e_ret, e_stall, e_halt, e_fault});
    @(negedge iClk);
    obs = {oStep, oIREn, oRetire, oStall, oHalted, oFault};
    exp = exp_q.pop_front();
    chk(tag, 32'(obs), 32'(exp));
    @(posedge iClk);
    #1;
  endtask

  // Reset with otherwise-active inputs; strobes must stay low and all state returns to reset values.
  task automatic do_reset(input string tag);
    iRst = 1'b1; iRdy = 1'b1; iLastStep = 1'b1; iHalt = 1'b0; iResume = 1'b1;
    iMemReq = 1'b1; iMemAck = 1'b1;
    @(negedge iClk);
    chk({tag, "_strobes"}, 32'({oIREn, oRetire, oStall}), 32'd0);
    @(posedge iClk);
    #1;
    iRst = 1'b0; iRdy = 1'b0; iLastStep = 1'b0; iResume = 1'b0;
    iMemReq = 1'b0; iMemAck = 1'b0;
    chk({tag, "_step"},   32'(oStep), 32'd1);
    chk({tag, "_state"},  32'(oState), 32'(SEQ_RUN));
    chk({tag, "_flags"},  32'({oHalted, oFault}), 32'd0);
    chk({tag, "_cnts"},   32'({oInstrCnt, oCycleCnt}), 32'd0);
    chk({tag, "_t_step"}, 32'(t_step), 32'd1);
    chk({tag, "_t_flt"},  32'({t_halted, t_fault}), 32'd0);
    chk({tag, "_t_cnts"}, 32'({t_instr, t_cycle}), 32'd0);
  endtask

  initial begin
    iRst = 1'b1; iRdy = 1'b0; iLastStep = 1'b0; iHalt = 1'b0; iResume = 1'b0;
    iMemReq = 1'b0; iMemAck = 1'b0;

    // 1: three-step instruction with zero-wait fetch (iResume in RUN is ignored)
    do_reset("rst1");
    cyc("t1_fetch", 1,0,0,0,1,1, 5'd1, 1,0,0,0,0);
    cyc("t1_s2",    1,0,0,1,0,0, 5'd2, 0,0,0,0,0);
    cyc("t1_s3",    1,1,0,0,0,0, 5'd4, 0,1,0,0,0);
    chk("t1_step_end", 32'(oStep), 32'd1);
    chk("t1_instr",    32'(oInstrCnt), 32'd1);
    chk("t1_cycle",    32'(oCycleCnt), 32'd3);

    // 2: fetch ack 4 cycles after request, then walk to the top step and wrap
    do_reset("rst2");
    cyc("t2_req", 1,0,0,0,1,0, 5'd1, 0,0,1,0,0);
    chk("t2_state_wait", 32'(oState), 32'(SEQ_WAIT));
    for (int i = 0; i < 3; i++) cyc("t2_wait", 1,0,0,0,1,0, 5'd1, 0,0,1,0,0);
    cyc("t2_ack", 1,0,0,0,1,1, 5'd1, 1,0,0,0,0);
    cyc("t2_s2",  1,0,0,0,0,0, 5'd2, 0,0,0,0,0);
    cyc("t2_s3",  1,0,0,0,0,0, 5'd4, 0,0,0,0,0);
    cyc("t2_s4",  1,0,0,0,0,0, 5'd8, 0,0,0,0,0);
    cyc("t2_s5",  1,0,0,0,0,0, 5'd16, 0,1,0,0,0);
    chk("t2_wrap",  32'(oStep), 32'd1);
    chk("t2_instr", 32'(oInstrCnt), 32'd1);
    chk("t2_cycle", 32'(oCycleCnt), 32'd9);

    // 3: ack pulse while not ready, advance once iRdy returns two cycles later
    do_reset("rst3");
    cyc("t3_req",    1,0,0,0,1,0, 5'd1, 0,0,1,0,0);
    cyc("t3_ack",    0,0,0,0,1,1, 5'd1, 0,0,1,0,0);
    cyc("t3_hold",   0,0,0,0,1,0, 5'd1, 0,0,1,0,0);
    cyc("t3_adv",    1,0,0,0,1,0, 5'd1, 1,0,0,0,0);
    cyc("t3_last",   1,1,0,0,0,0, 5'd2, 0,1,0,0,0);
    chk("t3_instr",  32'(oInstrCnt), 32'd1);

    // 4: halt together with last step, counters frozen, then resume and fetch
    do_reset("rst4");
    cyc("t4_fetch", 1,0,0,0,1,1, 5'd1, 1,0,0,0,0);
    cyc("t4_halt",  1,1,1,0,0,0, 5'd2, 0,1,0,0,0);
    for (int i = 0; i < 3; i++) cyc("t4_halted", 1,0,0,0,0,0, 5'd1, 0,0,0,1,0);
    chk("t4_instr",  32'(oInstrCnt), 32'd1);
    chk("t4_cycle",  32'(oCycleCnt), 32'd2);
    cyc("t4_resume", 1,0,0,1,0,0, 5'd1, 0,0,0,1,0);
    chk("t4_state_run", 32'(oState), 32'(SEQ_RUN));
    cyc("t4_fetch2", 1,0,0,0,1,1, 5'd1, 1,0,0,0,0);
    chk("t4_step2",  32'(oStep), 32'd2);
    chk("t4_cycle2", 32'(oCycleCnt), 32'd3);

    // 5: short-timeout instance faults after 3 WAIT cycles; main instance keeps waiting
    do_reset("rst5");
    cyc("t5_req", 1,0,0,0,1,0, 5'd1, 0,0,1,0,0);
    chk("t5_t_wait", 32'(t_state), 32'(SEQ_WAIT));
    for (int i = 0; i < 3; i++) begin
      cyc("t5_wait", 1,0,0,0,1,0, 5'd1, 0,0,1,0,0);
      chk("t5_t_fault", 32'(t_fault), (i == 2) ? 32'd1 : 32'd0);
    end
    cyc("t5_resume", 1,0,0,1,1,0, 5'd1, 0,0,1,0,0);
    chk("t5_t_still_fault", 32'({t_halted, t_fault}), 32'd1);
    chk("t5_t_step",  32'(t_step), 32'd1);
    chk("t5_t_cycle", 32'(t_cycle), 32'd4);
    chk("t5_t_stall", 32'(t_stall), 32'd0);
    do_reset("rst5b");

    // 6: 17 fetch+one-step instructions wrap the 4-bit retire counter
    exp_cyc = 0;
    for (int k = 0; k < 17; k++) begin
      cyc("t6_fetch", 1,0,0,0,1,1, 5'd1, 1,0,0,0,0);
      n_idle = $urandom_range(0, 2);
      for (int j = 0; j < n_idle; j++) cyc("t6_idle", 0,0,0,0,0,0, 5'd2, 0,0,1,0,0);
      cyc("t6_last", 1,1,0,0,0,0, 5'd2, 0,1,0,0,0);
      exp_cyc += 2 + n_idle;
    end
    chk("t6_instr_wrap", 32'(oInstrCnt), 32'd1);
    chk("t6_cycle_wrap", 32'(oCycleCnt), 32'(exp_cyc % 16));

    // reset while waiting on memory
    cyc("t6_req", 1,0,0,0,1,0, 5'd1, 0,0,1,0,0);
    chk("t6_state_wait", 32'(oState), 32'(SEQ_WAIT));
    do_reset("rst6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
